// File: rtl/rv32i_pkg.sv
// Shared rv32i pipeline types and widths.
// Imported by the back-end pipeline stages.
package rv32i_pkg;

  localparam int DPW = 32;

  typedef enum logic {
    RES_ALU = 1'b0,
    RES_MEM = 1'b1
  } result_src_t;

  typedef struct packed {
    result_src_t     resultsrc;
    logic            memwrite;
    logic            regwrite;
    logic [DPW-1:0]  alu_result;
    logic [DPW-1:0]  rd2;
  } ex_mem_t;

  typedef struct packed {
    result_src_t     resultsrc;
    logic            regwrite;
    logic [DPW-1:0]  alu_result;
    logic [DPW-1:0]  readdata;
  } mem_wb_t;

  function automatic logic [DPW-1:0] wb_mux(
    input result_src_t    src,
    input logic [DPW-1:0] alu,
    input logic [DPW-1:0] mem
  );
    return (src == RES_MEM) ? mem : alu;
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Register-file write port shared by writeback_stage
// (master) and decode_stage (slave).
interface writeback_stage_if #(
  parameter int ADW = 5
);
  import rv32i_pkg::*;

  logic            we;
  logic [ADW-1:0]  addr_3;
  logic [DPW-1:0]  wd_3;

  modport master (
    output we,
    output addr_3,
    output wd_3
  );

  modport slave (
    input we,
    input addr_3,
    input wd_3
  );

endinterface

// File: rtl/writeback_stage_data_mem.sv
// Word-addressed data memory: synchronous write,
// asynchronous read, contents survive reset.
module data_mem #(
  parameter int DPW      = 32,
  parameter int DM_DEPTH = 256
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [$clog2(DM_DEPTH)-1:0] addr,
  input  logic [DPW-1:0]              wd,
  output logic [DPW-1:0]              rd
);

  logic [DPW-1:0] r_mem [DM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wd;
    end
  end

  assign rd = r_mem[addr];

endmodule

// File: rtl/writeback_stage.sv
// rv32i back end: E->M and M->W pipeline registers,
// data memory and register-file writeback.
module writeback_stage
  import rv32i_pkg::*;
#(
  parameter int ADW      = 5,
  parameter int DM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flushM,
  input  logic              resultsrcE,
  input  logic              memwriteE,
  input  logic              regwriteE,
  input  logic [DPW-1:0]    alu_resultE,
  input  logic [DPW-1:0]    Rd2E,
  input  logic [ADW-1:0]    RdE,
  output logic              regwriteM,
  output logic [ADW-1:0]    RdM,
  output logic [DPW-1:0]    alu_resultM,
  output logic              regwriteW,
  output logic [ADW-1:0]    RdW,
  writeback_stage_if.master rf
);

  localparam int AW = $clog2(DM_DEPTH);

  ex_mem_t         r_m;
  logic [ADW-1:0]  r_RdM;
  mem_wb_t         r_w;
  logic [ADW-1:0]  r_RdW;

  logic [AW-1:0]   w_idx;
  logic            w_dm_we;
  logic [DPW-1:0]  w_readdataM;

  // flush bubbles only the control bits; data rides along
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m   <= '0;
      r_RdM <= '0;
    end else begin
      r_m.alu_result <= alu_resultE;
      r_m.rd2        <= Rd2E;
      if (flushM) begin
        r_m.resultsrc <= RES_ALU;
        r_m.memwrite  <= 1'b0;
        r_m.regwrite  <= 1'b0;
        r_RdM         <= '0;
      end else begin
        r_m.resultsrc <= result_src_t'(resultsrcE);
        r_m.memwrite  <= memwriteE;
        r_m.regwrite  <= regwriteE;
        r_RdM         <= RdE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_w   <= '0;
      r_RdW <= '0;
    end else begin
      r_w.resultsrc  <= r_m.resultsrc;
      r_w.regwrite   <= r_m.regwrite;
      r_w.alu_result <= r_m.alu_result;
      r_w.readdata   <= w_readdataM;
      r_RdW          <= r_RdM;
    end
  end

  // word index; low byte bits and high bits dropped
  assign w_idx   = r_m.alu_result[AW+1:2];
  assign w_dm_we = r_m.memwrite && !rst;

  data_mem #(
    .DPW      (DPW),
    .DM_DEPTH (DM_DEPTH)
  ) u_dmem (
    .clk  (clk),
    .we   (w_dm_we),
    .addr (w_idx),
    .wd   (r_m.rd2),
    .rd   (w_readdataM)
  );

  assign regwriteM   = r_m.regwrite;
  assign RdM         = r_RdM;
  assign alu_resultM = r_m.alu_result;
  assign regwriteW   = r_w.regwrite;
  assign RdW         = r_RdW;

  assign rf.we     = r_w.regwrite && (r_RdW != '0) && !rst;
  assign rf.addr_3 = r_RdW;
  assign rf.wd_3   = wb_mux(r_w.resultsrc, r_w.alu_result,
                            r_w.readdata);

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with
// hand-computed expected values.
module tb_writeback_stage;
  import rv32i_pkg::*;

  localparam int ADW      = 5;
  localparam int DM_DEPTH = 256;

  logic            clk;
  logic            rst;
  logic            flushM;
  logic            resultsrcE;
  logic            memwriteE;
  logic            regwriteE;
  logic [31:0]     alu_resultE;
  logic [31:0]     Rd2E;
  logic [ADW-1:0]  RdE;
  logic            regwriteM;
  logic [ADW-1:0]  RdM;
  logic [31:0]     alu_resultM;
  logic            regwriteW;
  logic [ADW-1:0]  RdW;

  int n_checks;
  int n_fail;

  writeback_stage_if #(.ADW(ADW)) rf ();

  writeback_stage #(
    .ADW      (ADW),
    .DM_DEPTH (DM_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flushM      (flushM),
    .resultsrcE  (resultsrcE),
    .memwriteE   (memwriteE),
    .regwriteE   (regwriteE),
    .alu_resultE (alu_resultE),
    .Rd2E        (Rd2E),
    .RdE         (RdE),
    .regwriteM   (regwriteM),
    .RdM         (RdM),
    .alu_resultM (alu_resultM),
    .regwriteW   (regwriteW),
    .RdW         (RdW),
    .rf          (rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic        rw,
    input logic        rs,
    input logic        mw,
    input logic [31:0] alu,
    input logic [31:0] d2,
    input logic [4:0]  rd
  );
    regwriteE   = rw;
    resultsrcE  = rs;
    memwriteE   = mw;
    alu_resultE = alu;
    Rd2E        = d2;
    RdE         = rd;
  endtask

  task automatic instr(
    input logic        rw,
    input logic        rs,
    input logic        mw,
    input logic [31:0] alu,
    input logic [31:0] d2,
    input logic [4:0]  rd
  );
    drive(rw, rs, mw, alu, d2, rd);
    tick();
  endtask

  task automatic nop();
    instr(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    flushM   = 1'b0;
    rst      = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h99, 32'h0, 5'd5);
    #1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_we",   {31'b0, rf.we}, 32'h0);
    chk("rst_wd3",  rf.wd_3, 32'h0);
    chk("rst_RdM",  {27'b0, RdM}, 32'h0);
    chk("rst_RdW",  {27'b0, RdW}, 32'h0);
    chk("rst_regwM", {31'b0, regwriteM}, 32'h0);

    // ALU writeback
    instr(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd7);
    chk("alu_RdM",  {27'b0, RdM}, 32'd7);
    chk("alu_resM", alu_resultM, 32'h1234);
    chk("alu_regwM", {31'b0, regwriteM}, 32'h1);
    alu_resultE = 32'hFFFF;
    RdE = 5'd30;
    #1;
    chk("nocomb_resM", alu_resultM, 32'h1234);
    chk("nocomb_RdM", {27'b0, RdM}, 32'd7);
    nop();
    chk("alu_we",   {31'b0, rf.we}, 32'h1);
    chk("alu_addr", {27'b0, rf.addr_3}, 32'd7);
    chk("alu_wd3",  rf.wd_3, 32'h1234);
    chk("alu_regwW", {31'b0, regwriteW}, 32'h1);

    // store then immediate load
    instr(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0);
    instr(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd3);
    nop();
    chk("sl_we",   {31'b0, rf.we}, 32'h1);
    chk("sl_addr", {27'b0, rf.addr_3}, 32'd3);
    chk("sl_wd3",  rf.wd_3, 32'hDEADBEEF);

    // address wrap and ignored byte offset
    instr(1'b0, 1'b0, 1'b1, 32'h408, 32'hA5A5, 5'd0);
    instr(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 5'd4);
    instr(1'b1, 1'b1, 1'b0, 32'hB, 32'h0, 5'd9);
    chk("wrap_addr", {27'b0, rf.addr_3}, 32'd4);
    chk("wrap_wd3",  rf.wd_3, 32'hA5A5);
    nop();
    chk("off_addr", {27'b0, rf.addr_3}, 32'd9);
    chk("off_wd3",  rf.wd_3, 32'hA5A5);

    // x0 never written
    instr(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 5'd0);
    nop();
    chk("x0_regwW", {31'b0, regwriteW}, 32'h1);
    chk("x0_we",    {31'b0, rf.we}, 32'h0);

    // flushed store leaves memory alone
    flushM = 1'b1;
    instr(1'b1, 1'b0, 1'b1, 32'h10, 32'h11112222, 5'd12);
    flushM = 1'b0;
    chk("fl_regwM", {31'b0, regwriteM}, 32'h0);
    chk("fl_RdM",   {27'b0, RdM}, 32'h0);
    instr(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd6);
    nop();
    chk("fl_wd3",  rf.wd_3, 32'hDEADBEEF);
    chk("fl_addr", {27'b0, rf.addr_3}, 32'd6);

    // reset with a store in M
    instr(1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 5'd8);
    instr(1'b0, 1'b0, 1'b1, 32'h10, 32'h33334444, 5'd0);
    rst = 1'b1;
    flushM = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 32'h10, 32'h5555, 5'd2);
    tick();
    rst = 1'b0;
    flushM = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    chk("mr_we",    {31'b0, rf.we}, 32'h0);
    chk("mr_wd3",   rf.wd_3, 32'h0);
    chk("mr_addr",  {27'b0, rf.addr_3}, 32'h0);
    chk("mr_RdM",   {27'b0, RdM}, 32'h0);
    chk("mr_resM",  alu_resultM, 32'h0);
    chk("mr_regwW", {31'b0, regwriteW}, 32'h0);
    instr(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd6);
    nop();
    chk("mr_mem", rf.wd_3, 32'hDEADBEEF);
    chk("mr_we2", {31'b0, rf.we}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
